bnn_act_packer: RTL and testbench

- Downstream stage of the BNN execute unit. Consumes the 1-bit activation result of each thresholded BNN operation and packs successive activations LSB-first into a 32-bit word.
- The packed word becomes the input feature vector for the next layer's XOR/XNOR-popcount operations.
- Sits in the execute stage beside the BNN unit. It is configured by an I-type immediate and drained by a read instruction that writes the packed word to the register file.

---
 rtl/bnn_pkg.sv | 23 ++
 rtl/bnn_act_packer_if.sv | 34 +++
 rtl/bnn_act_packer.sv | 115 +++++++++++
 tb/tb_bnn_act_packer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared BNN execute-stage definitions: widths, reset constants and the
// activation packer's state encoding.
package bnn_pkg;

  // Datapath width of the core, also the packed activation word width.
  localparam int BNN_XLEN = 32;

  // Width of the pack length / pack count fields (2**BNN_CNT_W > BNN_XLEN).
  localparam int BNN_CNT_W = 6;

  // Pack length after reset: a full XLEN-wide word.
  localparam int BNN_PACK_LEN_RST = 32;

  // Reset value of the BNN unit's matrix_size register.
  localparam int BNN_MATRIX_SIZE_RST = 9;

  // FILL: room for more activations; FULL: pack_count has reached pack_len.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_t;

endpackage

// File: rtl/bnn_act_packer_if.sv
// Execute-stage connection to the activation packer: activation stream,
// configuration/drain controls and the packed word status outputs.
interface bnn_act_packer_if
  import bnn_pkg::*;
#(
  parameter int WIDTH = BNN_XLEN,
  parameter int CNT_W = BNN_CNT_W
) ();

  logic             act_valid_E;
  logic             act_bit_E;
  logic             pl_WE;
  logic [31:0]      ExtImmE;
  logic             rd_en;
  logic             clr;
  logic [WIDTH-1:0] PackedWord;
  logic [CNT_W-1:0] pack_count;
  logic             pack_full;
  logic             pack_ready;
  logic             overflow;

  // Pipeline side: drives activations and control, observes the packer.
  modport master (
    output act_valid_E, act_bit_E, pl_WE, ExtImmE, rd_en, clr,
    input  PackedWord, pack_count, pack_full, pack_ready, overflow
  );

  // Packer side.
  modport slave (
    input  act_valid_E, act_bit_E, pl_WE, ExtImmE, rd_en, clr,
    output PackedWord, pack_count, pack_full, pack_ready, overflow
  );

endinterface

// File: rtl/bnn_act_packer.sv
// Packs thresholded BNN activation bits LSB-first into a WIDTH-bit word that
// feeds the next layer's XNOR-popcount. A read drains the word; a read with a
// same-cycle activation restarts the word with that bit at position 0.
module bnn_act_packer
  import bnn_pkg::*;
#(
  parameter int WIDTH = BNN_XLEN,
  parameter int CNT_W = BNN_CNT_W
) (
  input logic              clk,
  input logic              reset,
  bnn_act_packer_if.slave  bus
);

  // Map an immediate to a legal pack length: 0 becomes 1, anything above
  // WIDTH saturates at WIDTH.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
    if (v == '0) begin
      clamp_len = CNT_W'(1);
    end else if (int'(v) > WIDTH) begin
      clamp_len = CNT_W'(WIDTH);
    end else begin
      clamp_len = v;
    end
  endfunction

  pack_state_t      state_reg, state_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic             ovf_reg, ovf_next;

  // Bit position the incoming activation lands in: 0 when the word is being
  // drained in the same cycle, otherwise the current fill level.
  logic [CNT_W-1:0] slot_idx;
  logic [WIDTH-1:0] slot_sel;
  logic             accept;

  // Only the low CNT_W immediate bits carry the length.
  logic             unused_imm_hi;
  assign unused_imm_hi = ^bus.ExtImmE[31:CNT_W];

  assign slot_idx = bus.rd_en ? '0 : count_reg;

  // One-hot decode of the landing position.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
      assign slot_sel[gi] = (slot_idx == CNT_W'(gi));
    end
  endgenerate

  // An activation is taken when there is room or the word drains this cycle.
  assign accept = (state_reg == FILL) || bus.rd_en;

  // State register; reset discards the word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FILL;
      word_reg  <= '0;
      count_reg <= '0;
      len_reg   <= CNT_W'(WIDTH);
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      count_reg <= count_next;
      len_reg   <= len_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Next-state logic: clr beats pl_WE, which beats read/activation traffic.
  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    count_next = count_reg;
    len_next   = len_reg;
    ovf_next   = ovf_reg;

    if (bus.clr) begin
      state_next = FILL;
      word_next  = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (bus.pl_WE) begin
      len_next   = clamp_len(bus.ExtImmE[CNT_W-1:0]);
      state_next = FILL;
      word_next  = '0;
      count_next = '0;
    end else begin
      if (bus.rd_en) begin
        state_next = FILL;
        word_next  = '0;
        count_next = '0;
      end
      if (bus.act_valid_E) begin
        if (accept) begin
          // Unfilled bits are zero, so OR-ing the new bit in is enough.
          word_next  = word_next | (slot_sel & {WIDTH{bus.act_bit_E}});
          count_next = slot_idx + CNT_W'(1);
          state_next = (count_next == len_reg) ? FULL : FILL;
        end else begin
          ovf_next = 1'b1;
        end
      end
    end
  end

  assign bus.PackedWord = word_reg;
  assign bus.pack_count = count_reg;
  assign bus.pack_full  = (count_reg == len_reg);
  assign bus.pack_ready = (state_reg == FILL) || bus.rd_en;
  assign bus.overflow   = ovf_reg;

endmodule

// File: tb/tb_bnn_act_packer.sv
// Directed scoreboard bench for bnn_act_packer: stimulus pushes the outputs it
// expects for each observed cycle, a negedge monitor pops and compares.
module tb_bnn_act_packer;
  import bnn_pkg::*;

  localparam int W  = 32;
  localparam int CW = 6;

  typedef struct {
    string         name;
    int            cyc;
    logic [W-1:0]  word;
    logic [CW-1:0] cnt;
    logic          full;
    logic          ready;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  bnn_act_packer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  bnn_act_packer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Apply one cycle of inputs just after the active edge.
  task automatic drive(input logic v, input logic b, input logic pl,
                       input logic [31:0] imm, input logic rd, input logic c);
    @(posedge clk);
    #1;
    bus.act_valid_E = v;
    bus.act_bit_E   = b;
    bus.pl_WE       = pl;
    bus.ExtImmE     = imm;
    bus.rd_en       = rd;
    bus.clr         = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic push_bits(input logic [W-1:0] bits, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, bits[i], 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Expected outputs for the current cycle, given the inputs just applied.
  task automatic expect_now(input string name, input logic [W-1:0] w, input int cnt,
                            input logic full, input logic ready, input logic ovf);
    exp_t e;
    e.name  = name;
    e.cyc   = cyc_cnt;
    e.word  = w;
    e.cnt   = CW'(cnt);
    e.full  = full;
    e.ready = ready;
    e.ovf   = ovf;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation due by this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc_cnt || bus.PackedWord !== e.word || bus.pack_count !== e.cnt ||
            bus.pack_full !== e.full || bus.pack_ready !== e.ready || bus.overflow !== e.ovf) begin
          errors++;
          $display("FAIL %s: got word=%h cnt=%0d full=%b ready=%b ovf=%b, expected word=%h cnt=%0d full=%b ready=%b ovf=%b",
                   e.name, bus.PackedWord, bus.pack_count, bus.pack_full, bus.pack_ready, bus.overflow,
                   e.word, e.cnt, e.full, e.ready, e.ovf);
        end else begin
          $display("ok   %s: word=%h cnt=%0d full=%b ready=%b ovf=%b",
                   e.name, bus.PackedWord, bus.pack_count, bus.pack_full, bus.pack_ready, bus.overflow);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bus.act_valid_E = 1'b0;
    bus.act_bit_E   = 1'b0;
    bus.pl_WE       = 1'b0;
    bus.ExtImmE     = 32'd0;
    bus.rd_en       = 1'b0;
    bus.clr         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    expect_now("reset_hold", 32'h0, 0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    expect_now("after_reset", 32'h0, 0, 1'b0, 1'b1, 1'b0);

    // 32 alternating bits, 1 first
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, (i % 2 == 0), 1'b0, 32'd0, 1'b0, 1'b0);
      if (i == 16) expect_now("alt_half", 32'h0000_5555, 16, 1'b0, 1'b1, 1'b0);
    end
    idle();
    expect_now("alt_full", 32'h5555_5555, 32, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    expect_now("full_rd_ready", 32'h5555_5555, 32, 1'b1, 1'b1, 1'b0);

    // pack_len 9, then overflow on the 10th bit
    drive(1'b0, 1'b0, 1'b1, 32'd9, 1'b0, 1'b0);
    expect_now("pl9_cycle", 32'h0, 0, 1'b0, 1'b1, 1'b0);
    push_bits(32'h0000_01CB, 9);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_now("len9_full", 32'h0000_01CB, 9, 1'b1, 1'b0, 1'b0);
    idle();
    expect_now("len9_ovf", 32'h0000_01CB, 9, 1'b1, 1'b0, 1'b1);

    // clr drops word and overflow but keeps pack_len 9
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    idle();
    expect_now("after_clr", 32'h0, 0, 1'b0, 1'b1, 1'b0);
    push_bits(32'hFFFF_FFFF, 9);
    idle();
    expect_now("clr_keeps_len", 32'h0000_01FF, 9, 1'b1, 1'b0, 1'b0);

    // pack_len 4, read plus activation in the same cycle
    drive(1'b0, 1'b0, 1'b1, 32'd4, 1'b0, 1'b0);
    push_bits(32'hFFFF_FFFF, 4);
    idle();
    expect_now("len4_full", 32'h0000_000F, 4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    expect_now("rd_act_read", 32'h0000_000F, 4, 1'b1, 1'b1, 1'b0);
    idle();
    expect_now("rd_act_after", 32'h0, 1, 1'b0, 1'b1, 1'b0);

    // partial drain of 1,0,1
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    push_bits(32'h0000_0005, 3);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    expect_now("partial_read", 32'h0000_0005, 3, 1'b0, 1'b1, 1'b0);
    idle();
    expect_now("partial_after", 32'h0, 0, 1'b0, 1'b1, 1'b0);

    // clamp 0 -> 1; read+activation with pack_len 1 refills straight to FULL
    drive(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    expect_now("len1_full", 32'h0000_0001, 1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    expect_now("len1_rd_act", 32'h0000_0001, 1, 1'b1, 1'b1, 1'b0);
    idle();
    expect_now("len1_refull", 32'h0, 1, 1'b1, 1'b0, 1'b0);

    // clamp 40 -> 32 (upper immediate bits ignored)
    drive(1'b0, 1'b0, 1'b1, 32'hABCD_0028, 1'b0, 1'b0);
    push_bits(32'hFFFF_FFFF, 31);
    idle();
    expect_now("len40_31", 32'h7FFF_FFFF, 31, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    expect_now("len40_32", 32'hFFFF_FFFF, 32, 1'b1, 1'b0, 1'b0);

    // asynchronous reset with count 17 and overflow set
    drive(1'b0, 1'b0, 1'b1, 32'd17, 1'b0, 1'b0);
    push_bits(32'hFFFF_FFFF, 17);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    expect_now("len17_ovf", 32'h0001_FFFF, 17, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    expect_now("async_reset", 32'h0, 0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_bits(32'hFFFF_FFFF, 31);
    idle();
    expect_now("rst_len_31", 32'h7FFF_FFFF, 31, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    expect_now("rst_len_32", 32'hFFFF_FFFF, 32, 1'b1, 1'b0, 1'b0);

    // let the monitor drain the scoreboard, bounded
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
